cluster_clock_gate_ctrl: RTL and testbench
==========================================

// Module: cluster_clock_gate_ctrl
// PURPOSE
//  Per-channel clock-enable sequencer for the cluster's integrated clock-gate cells, one cell per core/channel.
//  - Watches each channel's busy status and gates its clock after a programmable idle hysteresis.
//  - Re-enables the clock on a wake request, waits for the clock to settle, then acknowledges.
//  - Sits between the cluster event/power unit and the per-core gate cells; clk_en_o[i] drives the cell's en_i.
// PARAMETERS
//  NUM_CH      4   number of gated channels
//  IDLE_CNT_W  8   width of idle-hysteresis counter and threshold
//  WAKE_LAT    2   cycles held in WAKING before ACTIVE (>=1)
//  STAT_W      32  width of per-channel gated-cycle counter (CLK_GATE_STATS_EN only)
// PORTS
//  clk_i            in   1               free-running cluster clock (ungated)
//  rst_ni           in   1               asynchronous reset, active low
//  test_en_i        in   1               scan/test mode: forces all channels ACTIVE
//  cfg_idle_thr_i   in   IDLE_CNT_W      idle cycles before gating; 0 = gating disabled
//  cfg_force_on_i   in   NUM_CH          per-channel keep-clock-on
//  busy_i           in   NUM_CH          channel busy (stale/ignored while GATED)
//  wake_req_i       in   NUM_CH          level wake request, held until wake_ack_o
//  wake_ack_o       out  NUM_CH          1-cycle ack pulse, clock running and stable
//  clk_en_o         out  NUM_CH          registered enable to gate cell en_i
//  gated_o          out  NUM_CH          registered, 1 while channel in GATED
//  stat_clr_i       in   1               clear all stat counters (CLK_GATE_STATS_EN only)
//  stat_gated_cnt_o out  NUM_CH*STAT_W   gated-cycle counts, ch0 in LSBs (CLK_GATE_STATS_EN only)
// BEHAVIOUR
//  Reset (async, rst_ni=0): every channel ACTIVE; clk_en_o='1, gated_o='0, wake_ack_o='0, counters 0.
//  Per-channel FSM; keep = busy_i|wake_req_i|cfg_force_on_i|test_en_i|(cfg_idle_thr_i==0):
//  - ACTIVE:    en=1. !keep -> IDLE_WAIT, idle_cnt<=0.
//  - IDLE_WAIT: en=1, idle_cnt++ (saturating). keep -> ACTIVE.
//               Else idle_cnt+1 >= cfg_idle_thr_i -> GATED. Threshold compared live; lowering it mid-wait gates immediately.
//  - GATED:     en=0, gated=1. busy_i ignored.
//               wake_req_i|cfg_force_on_i|test_en_i -> WAKING, wake_cnt<=0.
//  - WAKING:    en=1, wake_cnt++. wake_cnt==WAKE_LAT-1 -> ACTIVE. test_en_i -> ACTIVE at once.
//  Outputs: clk_en_o/gated_o registered from next state, so they change the same edge the state changes.
//  Gating latency: last non-keep cycle t in ACTIVE -> clk_en_o=0 from edge t+thr+1.
//  Wake latency: req sampled high in GATED at edge t -> clk_en_o=1 after t+1; ACTIVE after t+1+WAKE_LAT;
//    wake_ack_o high for the cycle after edge t+2+WAKE_LAT.
//  Ack rule: wake_ack_o[i] <= wake_req_i[i] & state==ACTIVE & !wake_ack_o[i].
//    - Never two consecutive acks.
//    - Requester drops req the cycle it sees ack.
//    - req in ACTIVE/IDLE_WAIT acks 2 cycles later (IDLE_WAIT returns to ACTIVE first).
//  Simultaneous: keep and threshold-reach in same cycle -> keep wins (stay ungated).
//    force_on and wake_req together in GATED -> single WAKING sequence, one ack if req held.
//  Channels fully independent; no cross-channel arbitration.
//  Reset mid-WAKING/GATED: immediately ACTIVE with en=1; any pending ack is dropped.
// CONFIGURATION
//  CLK_GATE_STATS_EN defined:
//    - stat_clr_i and stat_gated_cnt_o exist.
//    - Per-channel counter +1 each cycle clk_en_o[i]==0, saturating at all-ones.
//    - stat_clr_i zeroes all counters, wins over increment.
//  Not defined: both ports absent, no counters, FSM behaviour identical.
// STRUCTURE
//  Package cluster_clock_gate_ctrl_pkg:
//    - cg_state_e enum {CG_ACTIVE, CG_IDLE_WAIT, CG_GATED, CG_WAKING}, 2-bit.
//    - Reset-state constant CG_RESET_STATE = CG_ACTIVE.
//  Sub-module cluster_clock_gate_ch: one channel's FSM, idle/wake counters and ack, instantiated NUM_CH times via generate.
//  Top: parameter checks (WAKE_LAT>=1), optional stats counters, output packing.
// TESTING (NUM_CH=4, WAKE_LAT=2)
//  1. thr=4, busy[0] 1->0 at cycle 10, held low -> clk_en_o[0]=0, gated_o[0]=1 from cycle 15; other channels stay enabled.
//  2. ch0 GATED, wake_req[0]=1 at cycle 20 -> clk_en_o[0]=1 cycle 21, ACTIVE cycle 23, wake_ack_o[0] single pulse cycle 24.
//  3. thr=4, busy[1] pulses 1 at 3rd idle cycle -> counter restarts, no gating until 5 consecutive idle cycles follow.
//  4. thr=0, or cfg_force_on[2]=1, or test_en_i=1 while ch2 GATED -> never gates / WAKING then ACTIVE; test_en skips WAKING.
//  5. rst_ni low mid-WAKING ch3 -> clk_en_o[3]=1 immediately (async), no ack, ACTIVE after release.
//  6. CLK_GATE_STATS_EN: ch0 gated 37 cycles -> stat count 37; stat_clr_i with gating active -> reads 0 next cycle.

Source files
------------

// File: rtl/cluster_clock_gate_ctrl_pkg.sv
// Shared types for the cluster clock-gate sequencer: per-channel FSM states and the reset state.
package cluster_clock_gate_ctrl_pkg;

    typedef enum logic [1:0] {
        CG_ACTIVE    = 2'd0,
        CG_IDLE_WAIT = 2'd1,
        CG_GATED     = 2'd2,
        CG_WAKING    = 2'd3
    } cg_state_e;

    localparam cg_state_e CG_RESET_STATE = CG_ACTIVE;

    // The gate cell is enabled in every state except GATED.
    function automatic logic cg_clk_en(input cg_state_e state);
        logic en;
        case (state)
            CG_GATED: en = 1'b0;
            default:  en = 1'b1;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/cluster_clock_gate_ch.sv
// One channel of the clock-gate sequencer: idle hysteresis, wake settling and the wake acknowledge.
module cluster_clock_gate_ch
    import cluster_clock_gate_ctrl_pkg::*;
#(
    parameter int IDLE_CNT_W = 8,
    parameter int WAKE_LAT   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  test_en_i,
    input  logic [IDLE_CNT_W-1:0] idle_thr_i,
    input  logic                  force_on_i,
    input  logic                  busy_i,
    input  logic                  wake_req_i,
    output logic                  wake_ack_o,
    output logic                  clk_en_o,
    output logic                  gated_o
);

    localparam int WAKE_CNT_W = (WAKE_LAT > 1) ? $clog2(WAKE_LAT) : 1;
    localparam logic [WAKE_CNT_W-1:0] WAKE_LAST = WAKE_CNT_W'(WAKE_LAT - 1);

    cg_state_e             state_q, state_d;
    logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [WAKE_CNT_W-1:0] wake_cnt_q, wake_cnt_d;
    logic                  clk_en_q, clk_en_d;
    logic                  gated_q, gated_d;
    logic                  ack_q, ack_d;
    logic                  keep_s;
    logic                  wake_s;
    logic [IDLE_CNT_W:0]   idle_inc_s;

    // Next-state, counter and registered-output logic for the channel FSM.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        keep_s     = busy_i | wake_req_i | force_on_i | test_en_i |
                     (idle_thr_i == {IDLE_CNT_W{1'b0}});
        wake_s     = wake_req_i | force_on_i | test_en_i;
        // One extra bit so the saturating count and the live threshold compare never wrap.
        idle_inc_s = {1'b0, idle_cnt_q} + {{IDLE_CNT_W{1'b0}}, 1'b1};

        case (state_q)
            CG_ACTIVE: begin
                if (!keep_s) begin
                    state_d    = CG_IDLE_WAIT;
                    idle_cnt_d = {IDLE_CNT_W{1'b0}};
                end else begin
                    state_d = CG_ACTIVE;
                end
            end
            CG_IDLE_WAIT: begin
                if (idle_inc_s[IDLE_CNT_W]) begin
                    idle_cnt_d = idle_cnt_q;
                end else begin
                    idle_cnt_d = idle_inc_s[IDLE_CNT_W-1:0];
                end
                if (keep_s) begin
                    state_d = CG_ACTIVE;
                end else if (idle_inc_s >= {1'b0, idle_thr_i}) begin
                    state_d = CG_GATED;
                end else begin
                    state_d = CG_IDLE_WAIT;
                end
            end
            CG_GATED: begin
                if (wake_s) begin
                    state_d    = CG_WAKING;
                    wake_cnt_d = {WAKE_CNT_W{1'b0}};
                end else begin
                    state_d = CG_GATED;
                end
            end
            CG_WAKING: begin
                wake_cnt_d = wake_cnt_q + WAKE_CNT_W'(1);
                if (test_en_i || (wake_cnt_q == WAKE_LAST)) begin
                    state_d = CG_ACTIVE;
                end else begin
                    state_d = CG_WAKING;
                end
            end
            default: begin
                state_d = CG_RESET_STATE;
            end
        endcase

        clk_en_d = cg_clk_en(state_d);
        gated_d  = (state_d == CG_GATED);
        // Ack only once the clock is confirmed running; the !ack_q term forbids back-to-back pulses.
        ack_d    = wake_req_i & (state_q == CG_ACTIVE) & ~ack_q;
    end

    // State, counters and outputs; reset returns the channel to an ungated ACTIVE state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= CG_RESET_STATE;
            idle_cnt_q <= {IDLE_CNT_W{1'b0}};
            wake_cnt_q <= {WAKE_CNT_W{1'b0}};
            clk_en_q   <= 1'b1;
            gated_q    <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
            clk_en_q   <= clk_en_d;
            gated_q    <= gated_d;
            ack_q      <= ack_d;
        end
    end

    assign wake_ack_o = ack_q;
    assign clk_en_o   = clk_en_q;
    assign gated_o    = gated_q;

endmodule

// File: rtl/cluster_clock_gate_ctrl.sv
// Cluster clock-enable sequencer: one independent gating FSM per core/channel.
// Optional gated-cycle statistics are built when CLK_GATE_STATS_EN is defined.
module cluster_clock_gate_ctrl
    import cluster_clock_gate_ctrl_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int IDLE_CNT_W = 8,
    parameter int WAKE_LAT   = 2,
    parameter int STAT_W     = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    test_en_i,
    input  logic [IDLE_CNT_W-1:0]   cfg_idle_thr_i,
    input  logic [NUM_CH-1:0]       cfg_force_on_i,
    input  logic [NUM_CH-1:0]       busy_i,
    input  logic [NUM_CH-1:0]       wake_req_i,
    output logic [NUM_CH-1:0]       wake_ack_o,
    output logic [NUM_CH-1:0]       clk_en_o,
    output logic [NUM_CH-1:0]       gated_o
`ifdef CLK_GATE_STATS_EN
    ,
    input  logic                    stat_clr_i,
    output logic [NUM_CH*STAT_W-1:0] stat_gated_cnt_o
`endif
);

    if (WAKE_LAT < 1) begin : g_bad_wake_lat
        $error("cluster_clock_gate_ctrl: WAKE_LAT must be at least 1");
    end
    if (STAT_W < 1) begin : g_bad_stat_w
        $error("cluster_clock_gate_ctrl: STAT_W must be at least 1");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        cluster_clock_gate_ch #(
            .IDLE_CNT_W (IDLE_CNT_W),
            .WAKE_LAT   (WAKE_LAT)
        ) u_ch (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .test_en_i  (test_en_i),
            .idle_thr_i (cfg_idle_thr_i),
            .force_on_i (cfg_force_on_i[i]),
            .busy_i     (busy_i[i]),
            .wake_req_i (wake_req_i[i]),
            .wake_ack_o (wake_ack_o[i]),
            .clk_en_o   (clk_en_o[i]),
            .gated_o    (gated_o[i])
        );

`ifdef CLK_GATE_STATS_EN
        logic [STAT_W-1:0] stat_q, stat_d;

        // Saturating count of cycles this channel's gate cell is disabled; clear has priority.
        always_comb begin
            if (stat_clr_i) begin
                stat_d = {STAT_W{1'b0}};
            end else if (!clk_en_o[i] && (stat_q != {STAT_W{1'b1}})) begin
                stat_d = stat_q + STAT_W'(1);
            end else begin
                stat_d = stat_q;
            end
        end

        // Gated-cycle counter register.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                stat_q <= {STAT_W{1'b0}};
            end else begin
                stat_q <= stat_d;
            end
        end

        assign stat_gated_cnt_o[i*STAT_W +: STAT_W] = stat_q;
`endif
    end

endmodule

// File: tb/tb_cluster_clock_gate_ctrl.sv
// Scoreboard bench for cluster_clock_gate_ctrl: stimulus pushes expected outputs, a monitor checks them.
module tb_cluster_clock_gate_ctrl;

    localparam int NUM_CH     = 4;
    localparam int IDLE_CNT_W = 8;
    localparam int WAKE_LAT   = 2;
    localparam int STAT_W     = 32;

    logic                  clk_i = 1'b0;
    logic                  rst_ni = 1'b0;
    logic                  test_en_i = 1'b0;
    logic [IDLE_CNT_W-1:0] cfg_idle_thr_i = 8'd4;
    logic [NUM_CH-1:0]     cfg_force_on_i = 4'b0000;
    logic [NUM_CH-1:0]     busy_i = 4'b1111;
    logic [NUM_CH-1:0]     wake_req_i = 4'b0000;
    logic [NUM_CH-1:0]     wake_ack_o;
    logic [NUM_CH-1:0]     clk_en_o;
    logic [NUM_CH-1:0]     gated_o;
`ifdef CLK_GATE_STATS_EN
    logic                       stat_clr_i = 1'b0;
    logic [NUM_CH*STAT_W-1:0]   stat_gated_cnt_o;
`endif

    cluster_clock_gate_ctrl #(
        .NUM_CH     (NUM_CH),
        .IDLE_CNT_W (IDLE_CNT_W),
        .WAKE_LAT   (WAKE_LAT),
        .STAT_W     (STAT_W)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .test_en_i        (test_en_i),
        .cfg_idle_thr_i   (cfg_idle_thr_i),
        .cfg_force_on_i   (cfg_force_on_i),
        .busy_i           (busy_i),
        .wake_req_i       (wake_req_i),
        .wake_ack_o       (wake_ack_o),
        .clk_en_o         (clk_en_o),
        .gated_o          (gated_o)
`ifdef CLK_GATE_STATS_EN
        ,
        .stat_clr_i       (stat_clr_i),
        .stat_gated_cnt_o (stat_gated_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct { int cyc; logic [3:0] en; logic [3:0] gated; } out_exp_t;
    typedef struct { int cyc; int ch; } ack_exp_t;
    typedef struct { int cyc; int ch; logic [31:0] val; } stat_exp_t;

    out_exp_t  out_q[$];
    ack_exp_t  ack_q[$];
    stat_exp_t stat_q[$];

    int checks = 0;
    int errors = 0;

    task automatic goto(input int n);
        while (cyc != n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic exp_out(input int c, input logic [3:0] en, input logic [3:0] gated);
        out_exp_t e;
        e.cyc = c; e.en = en; e.gated = gated;
        out_q.push_back(e);
    endtask

    task automatic exp_ack(input int c, input int ch);
        ack_exp_t e;
        e.cyc = c; e.ch = ch;
        ack_q.push_back(e);
    endtask

    task automatic exp_stat(input int c, input int ch, input logic [31:0] val);
        stat_exp_t e;
        e.cyc = c; e.ch = ch; e.val = val;
        stat_q.push_back(e);
    endtask

    out_exp_t  m_out;
    ack_exp_t  m_ack;
    stat_exp_t m_stat;

    // Monitor: compare DUT outputs against queued expectations, mid-cycle.
    always @(negedge clk_i) begin
        while (out_q.size() > 0 && out_q[0].cyc <= cyc) begin
            m_out = out_q.pop_front();
            checks++;
            if (m_out.cyc != cyc) begin
                errors++;
                $display("FAIL out_missed cyc=%0d expected_at=%0d", cyc, m_out.cyc);
            end else if (clk_en_o !== m_out.en || gated_o !== m_out.gated) begin
                errors++;
                $display("FAIL out cyc=%0d clk_en=%b gated=%b required clk_en=%b gated=%b",
                         cyc, clk_en_o, gated_o, m_out.en, m_out.gated);
            end
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (wake_ack_o[ch] !== 1'b0) begin
                checks++;
                if (ack_q.size() > 0 && ack_q[0].ch == ch && ack_q[0].cyc == cyc) begin
                    m_ack = ack_q.pop_front();
                end else begin
                    errors++;
                    $display("FAIL ack_unexpected cyc=%0d ch=%0d ack=%b", cyc, ch, wake_ack_o);
                end
            end
        end
        while (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
            m_ack = ack_q.pop_front();
            checks++;
            errors++;
            $display("FAIL ack_missing ch=%0d required_at=%0d now=%0d", m_ack.ch, m_ack.cyc, cyc);
        end
`ifdef CLK_GATE_STATS_EN
        while (stat_q.size() > 0 && stat_q[0].cyc <= cyc) begin
            m_stat = stat_q.pop_front();
            checks++;
            if (m_stat.cyc != cyc) begin
                errors++;
                $display("FAIL stat_missed cyc=%0d expected_at=%0d", cyc, m_stat.cyc);
            end else if (stat_gated_cnt_o[m_stat.ch*STAT_W +: STAT_W] !== m_stat.val) begin
                errors++;
                $display("FAIL stat ch=%0d cyc=%0d got=%0d required=%0d", m_stat.ch, cyc,
                         stat_gated_cnt_o[m_stat.ch*STAT_W +: STAT_W], m_stat.val);
            end
        end
`endif
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, then idle gating of ch0 with thr=4.
        exp_out(1, 4'hF, 4'h0);
        goto(2);   rst_ni = 1'b1;
        exp_out(5, 4'hF, 4'h0);
        exp_out(14, 4'hF, 4'h0);
        exp_out(15, 4'hE, 4'h1);
        goto(10);  busy_i[0] = 1'b0;
        // busy ignored while gated.
        exp_out(19, 4'hE, 4'h1);
        goto(17);  busy_i[0] = 1'b1;
        // Wake ch0: enable next cycle, ack once ACTIVE.
        exp_out(20, 4'hE, 4'h1);
        exp_out(21, 4'hF, 4'h0);
        exp_out(23, 4'hF, 4'h0);
        exp_ack(24, 0);
        goto(20);  wake_req_i[0] = 1'b1;
        goto(24);  wake_req_i[0] = 1'b0;
        // ch1: a busy pulse in the idle window restarts the hysteresis.
        exp_out(35, 4'hF, 4'h0);
        exp_out(37, 4'hF, 4'h0);
        exp_out(38, 4'hD, 4'h2);
        goto(30);  busy_i[1] = 1'b0;
        goto(32);  busy_i[1] = 1'b1;
        goto(33);  busy_i[1] = 1'b0;
        // ch2: thr=0 disables gating.
        exp_out(45, 4'hD, 4'h2);
        exp_out(50, 4'hD, 4'h2);
        goto(40);  cfg_idle_thr_i = 8'd0; busy_i[2] = 1'b0;
        exp_out(55, 4'hD, 4'h2);
        exp_out(56, 4'h9, 4'h6);
        goto(51);  cfg_idle_thr_i = 8'd4;
        // ch2: force_on wakes without an ack, releases into gating again.
        exp_out(59, 4'hD, 4'h2);
        exp_out(62, 4'hD, 4'h2);
        exp_out(66, 4'hD, 4'h2);
        exp_out(67, 4'h9, 4'h6);
        goto(58);  cfg_force_on_i[2] = 1'b1;
        goto(62);  cfg_force_on_i[2] = 1'b0;
        // test_en cuts WAKING short: ch2 ack arrives one cycle earlier than a normal wake.
        exp_out(71, 4'hF, 4'h0);
        exp_ack(73, 2);
        exp_out(79, 4'hF, 4'h0);
        exp_out(80, 4'h9, 4'h6);
        goto(70);  test_en_i = 1'b1; wake_req_i[2] = 1'b1;
        goto(73);  wake_req_i[2] = 1'b0;
        goto(75);  test_en_i = 1'b0;
        // ch1: force_on and wake_req together give one wake and one ack.
        exp_out(83, 4'hB, 4'h4);
        exp_ack(86, 1);
        exp_out(90, 4'hB, 4'h4);
        exp_out(91, 4'h9, 4'h6);
        goto(82);  cfg_force_on_i[1] = 1'b1; wake_req_i[1] = 1'b1;
        goto(86);  cfg_force_on_i[1] = 1'b0; wake_req_i[1] = 1'b0;
        // ch3 gates, starts waking, then async reset.
        exp_out(96, 4'h9, 4'h6);
        exp_out(97, 4'h1, 4'hE);
        goto(92);  busy_i[3] = 1'b0;
        exp_out(100, 4'h1, 4'hE);
        exp_out(101, 4'hF, 4'h0);
        exp_out(102, 4'hF, 4'h0);
        exp_out(107, 4'hF, 4'h0);
        exp_out(108, 4'h1, 4'hE);
        goto(100); wake_req_i[3] = 1'b1;
        goto(101); rst_ni = 1'b0; wake_req_i[3] = 1'b0;
        goto(103); rst_ni = 1'b1;
        // ch0: lowering the threshold mid-wait gates on the next edge.
        exp_out(112, 4'h1, 4'hE);
        exp_out(113, 4'h0, 4'hF);
        goto(109); cfg_idle_thr_i = 8'd8;
        goto(110); busy_i[0] = 1'b0;
        goto(112); cfg_idle_thr_i = 8'd2;
`ifdef CLK_GATE_STATS_EN
        stat_clr_i = 1'b1;
        goto(113); stat_clr_i = 1'b0;
`endif
        // ch0 gated for 37 cycles, then woken.
        exp_out(150, 4'h1, 4'hE);
        exp_ack(153, 0);
        exp_out(160, 4'h1, 4'hE);
`ifdef CLK_GATE_STATS_EN
        exp_stat(150, 0, 32'd37);
        exp_stat(152, 0, 32'd37);
        exp_stat(155, 1, 32'd42);
        exp_stat(156, 1, 32'd0);
        exp_stat(157, 1, 32'd1);
`endif
        goto(149); wake_req_i[0] = 1'b1; busy_i[0] = 1'b1;
        goto(153); wake_req_i[0] = 1'b0;
`ifdef CLK_GATE_STATS_EN
        goto(155); stat_clr_i = 1'b1;
        goto(156); stat_clr_i = 1'b0;
`endif
        goto(163);
        if (out_q.size() != 0 || ack_q.size() != 0 || stat_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover out=%0d ack=%0d stat=%0d required=0",
                     out_q.size(), ack_q.size(), stat_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
